inst_mem_loader: RTL and testbench

- Parametrised, loadable instruction memory for the 16-bit MIPS core; replaces the hard-wired ROM.
- Program words stream in over a valid/ready load port.
- The fetch stage then reads with a registered, one-cycle-latency port.
- Locations not written by the most recent load read back as NOP, so a short program is always followed by NOPs.

---
 rtl/inst_mem_loader.sv | 92 +++++++++
 tb/tb_inst_mem_loader.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_mem_loader.sv
// Loadable instruction memory: programs stream in over a valid/ready port,
// then the fetch stage reads with one cycle of latency; unloaded words read as NOP.
module inst_mem_loader #(
  parameter int                DATA_W   = 16,
  parameter int                ADDR_W   = 10,
  parameter logic [DATA_W-1:0] NOP_WORD = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_start,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_last,
  output logic              load_ready,
  output logic              loading,
  output logic [ADDR_W:0]   load_count,
  input  logic              fetch_en,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic [DATA_W-1:0] inst,
  output logic              inst_valid
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] PTR_ONE = 1;
  localparam logic [ADDR_W:0]   CNT_ONE = 1;

  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] wr_ptr;
  logic              xfer;
  logic              start;
  logic              in_range;
  logic [DATA_W-1:0] mem [DEPTH];

  assign load_ready = (state == LOAD);
  assign loading    = (state == LOAD);
  assign xfer       = load_valid && load_ready;
  assign start      = load_start && (state != LOAD);
  // load_count masks stale words left behind by an earlier, longer program
  assign in_range   = ({1'b0, fetch_addr} < load_count);

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (load_start) state_nxt = LOAD;
      // a full memory ends the load even without load_last
      LOAD: if (xfer && (load_last || (&wr_ptr))) state_nxt = RUN;
      RUN:  if (load_start) state_nxt = LOAD;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      load_count <= '0;
    end else if (start) begin
      wr_ptr     <= '0;
      load_count <= '0;
    end else if (xfer) begin
      wr_ptr     <= wr_ptr + PTR_ONE;
      load_count <= load_count + CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (xfer) mem[wr_ptr] <= load_data;
  end

  // a load request wins over a same-cycle fetch
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inst       <= NOP_WORD;
      inst_valid <= 1'b0;
    end else if (start) begin
      inst       <= NOP_WORD;
      inst_valid <= 1'b0;
    end else if ((state == RUN) && fetch_en) begin
      inst       <= in_range ? mem[fetch_addr] : NOP_WORD;
      inst_valid <= 1'b1;
    end else begin
      inst_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_inst_mem_loader.sv
// Self-checking bench for inst_mem_loader: fetch results go through a scoreboard
// queue; a second small instance (ADDR_W=3) covers the full-memory stop.
module tb_inst_mem_loader;

  logic        clk = 1'b0;
  logic        rst_n, s_rst_n;
  logic        load_start, load_valid, load_last, fetch_en;
  logic [15:0] load_data;
  logic [9:0]  fetch_addr;
  logic        load_ready, loading, inst_valid;
  logic [10:0] load_count;
  logic [15:0] inst;

  logic        s_load_start, s_load_valid, s_load_last, s_fetch_en;
  logic [15:0] s_load_data;
  logic [2:0]  s_fetch_addr;
  logic        s_load_ready, s_loading, s_inst_valid;
  logic [3:0]  s_load_count;
  logic [15:0] s_inst;

  typedef struct {
    logic [15:0] inst;
    logic        valid;
    string       name;
  } exp_t;

  typedef struct {
    logic [9:0]  addr;
    logic [15:0] inst;
    string       name;
  } vec_t;

  exp_t exp_q[$];
  vec_t vecs[6];
  int   checks   = 0;
  int   failures = 0;
  int   accepted;

  always #5 clk = ~clk;

  inst_mem_loader #(.DATA_W(16), .ADDR_W(10), .NOP_WORD(16'h0000)) u_dut (
    .clk(clk), .rst_n(rst_n), .load_start(load_start), .load_valid(load_valid),
    .load_data(load_data), .load_last(load_last), .load_ready(load_ready),
    .loading(loading), .load_count(load_count), .fetch_en(fetch_en),
    .fetch_addr(fetch_addr), .inst(inst), .inst_valid(inst_valid)
  );

  inst_mem_loader #(.DATA_W(16), .ADDR_W(3), .NOP_WORD(16'h0000)) u_small (
    .clk(clk), .rst_n(s_rst_n), .load_start(s_load_start), .load_valid(s_load_valid),
    .load_data(s_load_data), .load_last(s_load_last), .load_ready(s_load_ready),
    .loading(s_loading), .load_count(s_load_count), .fetch_en(s_fetch_en),
    .fetch_addr(s_fetch_addr), .inst(s_inst), .inst_valid(s_inst_valid)
  );

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [9:0] addr, input logic [15:0] exp_inst, input string name);
    fetch_en   = 1'b1;
    fetch_addr = addr;
    exp_q.push_back('{exp_inst, 1'b1, name});
  endtask

  task automatic checkOutput();
    exp_t e;
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL scoreboard: got an output check with no expected entry queued");
    end else begin
      e = exp_q.pop_front();
      checkVal({e.name, "_valid"}, 32'(inst_valid), 32'(e.valid));
      if (e.valid) checkVal(e.name, 32'(inst), 32'(e.inst));
    end
  endtask

  task automatic startLoad();
    load_start = 1'b1;
    cycle();
    load_start = 1'b0;
  endtask

  task automatic sendWord(input logic [15:0] data, input logic last);
    load_valid = 1'b1;
    load_data  = data;
    load_last  = last;
    cycle();
    load_valid = 1'b0;
    load_last  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs[0] = '{10'd0,    16'h9201, "fetch_a0"};
    vecs[1] = '{10'd1,    16'h9402, "fetch_a1"};
    vecs[2] = '{10'd4,    16'h0000, "fetch_a4_nop"};
    vecs[3] = '{10'd1023, 16'h0000, "fetch_a1023_nop"};
    vecs[4] = '{10'd2,    16'h0000, "fetch_a2"};
    vecs[5] = '{10'd1,    16'h9402, "fetch_a1_again"};

    rst_n = 1'b0; s_rst_n = 1'b0;
    load_start = 1'b0; load_valid = 1'b0; load_last = 1'b0; load_data = '0;
    fetch_en = 1'b0; fetch_addr = '0;
    s_load_start = 1'b0; s_load_valid = 1'b0; s_load_last = 1'b0; s_load_data = '0;
    s_fetch_en = 1'b0; s_fetch_addr = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1; s_rst_n = 1'b1;

    checkVal("por_inst", 32'(inst), 32'h0);
    checkVal("por_inst_valid", 32'(inst_valid), 32'h0);
    checkVal("por_load_ready", 32'(load_ready), 32'h0);
    checkVal("por_loading", 32'(loading), 32'h0);
    checkVal("por_load_count", 32'(load_count), 32'h0);

    fetch_en = 1'b1;
    fetch_addr = 10'd0;
    exp_q.push_back('{16'h0000, 1'b0, "idle_fetch"});
    cycle();
    checkOutput();
    fetch_en = 1'b0;

    // first program, with a bubble after the second word
    startLoad();
    checkVal("load_loading", 32'(loading), 32'h1);
    checkVal("load_ready", 32'(load_ready), 32'h1);
    checkVal("load_count_start", 32'(load_count), 32'h0);
    sendWord(16'h9201, 1'b0);
    sendWord(16'h9402, 1'b0);
    cycle();
    checkVal("bubble_count", 32'(load_count), 32'd2);
    checkVal("bubble_loading", 32'(loading), 32'h1);
    sendWord(16'h0000, 1'b0);
    sendWord(16'h0000, 1'b1);
    checkVal("prog1_count", 32'(load_count), 32'd4);
    checkVal("prog1_loading", 32'(loading), 32'h0);
    checkVal("prog1_ready", 32'(load_ready), 32'h0);

    for (int i = 0; i < 6; i++) begin
      applyStimulus(vecs[i].addr, vecs[i].inst, vecs[i].name);
      cycle();
      checkOutput();
    end
    fetch_en = 1'b0;
    exp_q.push_back('{16'h0000, 1'b0, "idle_cycle"});
    cycle();
    checkOutput();
    checkVal("hold_inst", 32'(inst), 32'h9402);

    // load request collides with a fetch
    load_start = 1'b1;
    fetch_en   = 1'b1;
    fetch_addr = 10'd1;
    exp_q.push_back('{16'h0000, 1'b0, "collide"});
    cycle();
    load_start = 1'b0;
    checkOutput();
    checkVal("collide_inst", 32'(inst), 32'h0);
    checkVal("collide_loading", 32'(loading), 32'h1);
    checkVal("collide_count", 32'(load_count), 32'h0);
    fetch_addr = 10'd0;
    sendWord(16'h1234, 1'b0);
    checkVal("load_fetch_ignored", 32'(inst_valid), 32'h0);
    fetch_en = 1'b0;
    sendWord(16'hABCD, 1'b1);
    checkVal("prog2_count", 32'(load_count), 32'd2);
    checkVal("prog2_loading", 32'(loading), 32'h0);
    applyStimulus(10'd2, 16'h0000, "prog2_a2_masked");
    cycle();
    checkOutput();
    applyStimulus(10'd0, 16'h1234, "prog2_a0");
    cycle();
    checkOutput();
    applyStimulus(10'd1, 16'hABCD, "prog2_a1");
    cycle();
    checkOutput();

    // asynchronous reset in the middle of a clock period
    #3;
    rst_n = 1'b0;
    #1;
    checkVal("arst_inst", 32'(inst), 32'h0);
    checkVal("arst_inst_valid", 32'(inst_valid), 32'h0);
    checkVal("arst_load_ready", 32'(load_ready), 32'h0);
    checkVal("arst_loading", 32'(loading), 32'h0);
    checkVal("arst_load_count", 32'(load_count), 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    fetch_addr = 10'd0;
    exp_q.push_back('{16'h0000, 1'b0, "idle_fetch2"});
    cycle();
    checkOutput();
    fetch_en = 1'b0;

    // reset after three of five words
    startLoad();
    sendWord(16'hA0A0, 1'b0);
    sendWord(16'hB1B1, 1'b0);
    sendWord(16'hC2C2, 1'b0);
    checkVal("partial_count", 32'(load_count), 32'd3);
    #3;
    rst_n = 1'b0;
    #1;
    checkVal("abort_loading", 32'(loading), 32'h0);
    checkVal("abort_count", 32'(load_count), 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    startLoad();
    sendWord(16'h5555, 1'b1);
    checkVal("reload_count", 32'(load_count), 32'd1);
    checkVal("reload_loading", 32'(loading), 32'h0);
    applyStimulus(10'd0, 16'h5555, "reload_a0");
    cycle();
    checkOutput();
    applyStimulus(10'd1, 16'h0000, "reload_a1_masked");
    cycle();
    checkOutput();
    fetch_en = 1'b0;

    // small memory: ten words offered, no load_last
    s_load_start = 1'b1;
    cycle();
    s_load_start = 1'b0;
    accepted = 0;
    for (int i = 0; i < 10; i++) begin
      s_load_valid = 1'b1;
      s_load_data  = 16'(16'h1000 + i);
      checkVal($sformatf("small_ready_%0d", i), 32'(s_load_ready), 32'(i < 8));
      if (s_load_ready) accepted++;
      cycle();
    end
    s_load_valid = 1'b0;
    checkVal("small_accepted", 32'(accepted), 32'd8);
    checkVal("small_count", 32'(s_load_count), 32'd8);
    checkVal("small_loading", 32'(s_loading), 32'h0);
    s_fetch_en   = 1'b1;
    s_fetch_addr = 3'd7;
    cycle();
    checkVal("small_a7_valid", 32'(s_inst_valid), 32'h1);
    checkVal("small_a7", 32'(s_inst), 32'h1007);
    s_fetch_addr = 3'd0;
    cycle();
    checkVal("small_a0_valid", 32'(s_inst_valid), 32'h1);
    checkVal("small_a0_nowrap", 32'(s_inst), 32'h1000);
    s_fetch_en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
